spu_dual_issue_ctrl: RTL and testbench

- Producer side of the decode/register-fetch pipeline register in the dual-issue SPU.
- Accepts one decoded instruction pair per handshake and buffers it.
- Resolves structural hazards (same pipe), intra-pair hazards and scoreboard hazards (RAW/WAW on the 128-entry register file).
- Drives the even-pipe (_ID1) and odd-pipe (_ID2) inputs of the ID/REG register, in order, inserting NOPs where an instruction cannot issue.

---
 rtl/spu_pkg.sv | 39 +++
 rtl/spu_scoreboard.sv | 41 ++++
 rtl/spu_dual_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_spu_dual_issue_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU dual-issue front end.
package spu_pkg;

  localparam int NUM_REGS = 128;
  localparam int REG_W    = 7;
  localparam int LAT_W    = 3;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  // Decoded instruction as handed to the ID/REG register (96 bits, valid in MSB).
  typedef struct packed {
    logic             valid;
    logic             pipe;
    logic             regWriteEnable;
    logic             source;
    logic [6:0]       control;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] rt;
    logic             use_ra;
    logic             use_rb;
    logic             use_rc;
    logic [LAT_W-1:0] lat;
    logic [6:0]       imm7;
    logic [9:0]       imm10;
    logic [15:0]      imm16;
    logic [17:0]      imm18;
  } dec_inst_t;

  localparam dec_inst_t NOP_INST = '0;

  // Counter value loaded at issue: the consumer may go lat cycles later.
  function automatic logic [LAT_W-1:0] sb_load(input logic [LAT_W-1:0] lat);
    return (lat <= LAT_W'(1)) ? '0 : lat - 1'b1;
  endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register busy counters; a register is ready when its counter is zero.
import spu_pkg::*;

module spu_scoreboard (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            wr_en_i,
  input  logic [1:0][REG_W-1:0] wr_rt_i,
  input  logic [1:0][LAT_W-1:0] wr_lat_i,
  input  logic [7:0][REG_W-1:0] rd_reg_i,
  output logic [7:0]            rd_rdy_o
);

  logic [NUM_REGS-1:0] reg_rdy;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_ent
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Decrement toward zero; a load from an issuing writer takes priority
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (wr_en_i[0] && wr_rt_i[0] == REG_W'(r)) cnt_d = sb_load(wr_lat_i[0]);
      if (wr_en_i[1] && wr_rt_i[1] == REG_W'(r)) cnt_d = sb_load(wr_lat_i[1]);
    end

    // Counter register
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign reg_rdy[r] = (cnt_q == '0);
  end

  // Ready lookups for both slots' sources and destinations
  always_comb begin
    for (int k = 0; k < 8; k++) rd_rdy_o[k] = reg_rdy[rd_reg_i[k]];
  end

endmodule

// File: rtl/spu_dual_issue_ctrl.sv
// Pair buffer, in-order dual-issue hazard logic and even/odd pipe routing.
import spu_pkg::*;

module spu_dual_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  dec_inst_t        in_slot1,
  input  dec_inst_t        in_slot2,
  input  logic             flush,
  output dec_inst_t        iss_even,
  output dec_inst_t        iss_odd,
  output logic [CNT_W-1:0] stall_cycles
);

  dec_inst_t        slot1_q, slot1_d, slot2_q, slot2_d;
  logic             buf_valid_q, buf_valid_d;
  logic             pend1_q, pend1_d, pend2_q, pend2_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [7:0][REG_W-1:0] rd_reg;
  logic [7:0]            rdy;
  logic [1:0]            wr_en;
  logic                  live, src_ok1, src_ok2, pair_ok;
  logic                  iss1, iss2, all_done, accept, stall_inc;

  assign rd_reg = {slot2_q.rt, slot2_q.rc, slot2_q.rb, slot2_q.ra,
                   slot1_q.rt, slot1_q.rc, slot1_q.rb, slot1_q.ra};
  assign wr_en  = {iss2 & slot2_q.regWriteEnable, iss1 & slot1_q.regWriteEnable};

  spu_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .wr_rt_i  ({slot2_q.rt, slot1_q.rt}),
    .wr_lat_i ({slot2_q.lat, slot1_q.lat}),
    .rd_reg_i (rd_reg),
    .rd_rdy_o (rdy)
  );

  // Issue decision: slot1 on scoreboard only, slot2 also strictly behind slot1
  // and free of same-cycle pipe/RAW/WAW conflicts with it
  always_comb begin
    live    = buf_valid_q & ~flush & ~reset;
    src_ok1 = (~slot1_q.use_ra | rdy[0]) & (~slot1_q.use_rb | rdy[1]) &
              (~slot1_q.use_rc | rdy[2]) & (~slot1_q.regWriteEnable | rdy[3]);
    src_ok2 = (~slot2_q.use_ra | rdy[4]) & (~slot2_q.use_rb | rdy[5]) &
              (~slot2_q.use_rc | rdy[6]) & (~slot2_q.regWriteEnable | rdy[7]);
    pair_ok = (slot1_q.pipe != slot2_q.pipe) &
              ~(slot1_q.regWriteEnable &
                ((slot2_q.use_ra & (slot2_q.ra == slot1_q.rt)) |
                 (slot2_q.use_rb & (slot2_q.rb == slot1_q.rt)) |
                 (slot2_q.use_rc & (slot2_q.rc == slot1_q.rt)))) &
              ~(slot1_q.regWriteEnable & slot2_q.regWriteEnable &
                (slot1_q.rt == slot2_q.rt));
    iss1      = live & pend1_q & src_ok1;
    iss2      = live & pend2_q & (~pend1_q | iss1) & src_ok2 & (~iss1 | pair_ok);
    all_done  = (~pend1_q | iss1) & (~pend2_q | iss2);
    in_ready  = ~reset & ~flush & (~buf_valid_q | all_done);
    accept    = in_valid & in_ready;
    stall_inc = buf_valid_q & ~flush & ~all_done;
  end

  // Route issuing slots to their pipe; idle outputs carry a NOP
  always_comb begin
    iss_even = NOP_INST;
    iss_odd  = NOP_INST;
    if (iss1) begin
      if (slot1_q.pipe == PIPE_EVEN) iss_even = slot1_q;
      else                           iss_odd  = slot1_q;
    end
    if (iss2) begin
      if (slot2_q.pipe == PIPE_EVEN) iss_even = slot2_q;
      else                           iss_odd  = slot2_q;
    end
  end

  // Buffer next state: flush drops the pair, accept reloads, else retire issued slots
  always_comb begin
    slot1_d     = slot1_q;
    slot2_d     = slot2_q;
    buf_valid_d = buf_valid_q;
    pend1_d     = pend1_q;
    pend2_d     = pend2_q;
    if (flush) begin
      buf_valid_d = 1'b0;
      pend1_d     = 1'b0;
      pend2_d     = 1'b0;
    end else if (accept) begin
      slot1_d     = in_slot1;
      slot2_d     = in_slot2;
      buf_valid_d = 1'b1;
      pend1_d     = in_slot1.valid;
      pend2_d     = in_slot2.valid;
    end else begin
      pend1_d     = pend1_q & ~iss1;
      pend2_d     = pend2_q & ~iss2;
      buf_valid_d = buf_valid_q & (pend1_d | pend2_d);
    end
  end

  // Saturating count of cycles where a pending slot was held back
  always_comb begin
    stall_d = stall_q;
    if (stall_inc && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      slot1_q     <= NOP_INST;
      slot2_q     <= NOP_INST;
      buf_valid_q <= 1'b0;
      pend1_q     <= 1'b0;
      pend2_q     <= 1'b0;
      stall_q     <= '0;
    end else begin
      slot1_q     <= slot1_d;
      slot2_q     <= slot2_d;
      buf_valid_q <= buf_valid_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
      stall_q     <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_spu_dual_issue_ctrl.sv
// Directed bench for spu_dual_issue_ctrl with hand-computed expectations.
import spu_pkg::*;

module tb_spu_dual_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush;
  dec_inst_t   in_slot1, in_slot2, iss_even, iss_odd;
  logic [15:0] stall_cycles;

  int checks = 0;
  int fails  = 0;

  spu_dual_issue_ctrl #(.CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_slot1     (in_slot1),
    .in_slot2     (in_slot2),
    .flush        (flush),
    .iss_even     (iss_even),
    .iss_odd      (iss_odd),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic dec_inst_t mk(input logic pipe, input logic rwe, input logic [6:0] rt,
                                   input logic [2:0] lat, input logic [6:0] ra, input logic ura,
                                   input logic [6:0] rb, input logic urb, input logic [6:0] ctl);
    dec_inst_t d = '0;
    d.valid = 1'b1; d.pipe = pipe; d.regWriteEnable = rwe; d.rt = rt; d.lat = lat;
    d.ra = ra; d.use_ra = ura; d.rb = rb; d.use_rb = urb; d.control = ctl;
    d.imm18 = {11'h5a5, ctl};
    return d;
  endfunction

  // Reset for one edge; checks reset-cycle outputs and post-reset state
  task automatic rst_seq(input string tag);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_slot1 = NOP_INST; in_slot2 = NOP_INST;
    #1;
    chk({tag, "_rst_rdy"}, 96'(in_ready), 96'(0));
    chk({tag, "_rst_even"}, iss_even, NOP_INST);
    tick();
    reset = 1'b0;
    #1;
    chk({tag, "_post_stall"}, 96'(stall_cycles), 96'(0));
    chk({tag, "_post_rdy"}, 96'(in_ready), 96'(1));
  endtask

  // Present a pair for one edge; returns #1 into the following cycle
  task automatic offer(input dec_inst_t a, input dec_inst_t b);
    in_valid = 1'b1; in_slot1 = a; in_slot2 = b;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  // Scan cycles from c0 for the first valid issue on one pipe (bounded)
  task automatic find_iss(input logic odd, input int c0, output int n, output dec_inst_t got);
    n = 0; got = NOP_INST;
    for (int c = c0; c < c0 + 16; c++) begin
      if (odd ? iss_odd.valid : iss_even.valid) begin
        n = c; got = odd ? iss_odd : iss_even; break;
      end
      tick(); #1;
    end
  endtask

  dec_inst_t a1, a2, b1, b2, got;
  int n;

  initial begin
    // T1: independent pair, back-to-back accept, routing by pipe
    rst_seq("t1");
    a1 = mk(PIPE_EVEN, 1, 7'd3, 3'd2, 7'd0, 0, 7'd0, 0, 7'h11);
    a2 = mk(PIPE_ODD,  1, 7'd4, 3'd1, 7'd0, 0, 7'd0, 0, 7'h12);
    b1 = mk(PIPE_ODD,  1, 7'd20, 3'd1, 7'd0, 0, 7'd0, 0, 7'h13);
    b2 = mk(PIPE_EVEN, 1, 7'd21, 3'd1, 7'd0, 0, 7'd0, 0, 7'h14);
    offer(a1, a2);
    in_valid = 1'b1; in_slot1 = b1; in_slot2 = b2;
    chk("t1_c1_even", iss_even, a1);
    chk("t1_c1_odd", iss_odd, a2);
    chk("t1_c1_rdy", 96'(in_ready), 96'(1));
    tick(); in_valid = 1'b0; #1;
    chk("t1_c2_even", iss_even, b2);
    chk("t1_c2_odd", iss_odd, b1);
    tick(); #1;
    chk("t1_c3_even", iss_even, NOP_INST);
    chk("t1_stall", 96'(stall_cycles), 96'(0));

    // T2: same pipe -> serialised on iss_even
    rst_seq("t2");
    a1 = mk(PIPE_EVEN, 1, 7'd8, 3'd1, 7'd0, 0, 7'd0, 0, 7'h21);
    a2 = mk(PIPE_EVEN, 1, 7'd9, 3'd1, 7'd0, 0, 7'd0, 0, 7'h22);
    offer(a1, a2);
    chk("t2_c1_even", iss_even, a1);
    chk("t2_c1_odd", iss_odd, NOP_INST);
    chk("t2_c1_rdy", 96'(in_ready), 96'(0));
    tick(); #1;
    chk("t2_c2_even", iss_even, a2);
    chk("t2_c2_odd", iss_odd, NOP_INST);
    tick(); #1;
    chk("t2_stall", 96'(stall_cycles), 96'(1));

    // T3: intra-pair RAW on lat 4 -> slot2 issues 4 cycles after slot1, 4 stall cycles
    rst_seq("t3");
    a1 = mk(PIPE_EVEN, 1, 7'd5, 3'd4, 7'd0, 0, 7'd0, 0, 7'h31);
    a2 = mk(PIPE_ODD,  1, 7'd14, 3'd1, 7'd5, 1, 7'd0, 0, 7'h32);
    offer(a1, a2);
    chk("t3_c1_even", iss_even, a1);
    chk("t3_c1_odd", iss_odd, NOP_INST);
    tick(); #1;
    find_iss(1'b1, 2, n, got);
    chk("t3_cycle", 96'(n), 96'(5));
    chk("t3_inst", got, a2);
    tick(); #1;
    chk("t3_stall", 96'(stall_cycles), 96'(4));

    // T4: WAW against an in-flight lat 6 write -> next slot1 issues 6 cycles later
    rst_seq("t4");
    a1 = mk(PIPE_EVEN, 1, 7'd7, 3'd6, 7'd0, 0, 7'd0, 0, 7'h41);
    b1 = mk(PIPE_EVEN, 1, 7'd7, 3'd1, 7'd0, 0, 7'd0, 0, 7'h42);
    offer(a1, NOP_INST);
    in_valid = 1'b1; in_slot1 = b1; in_slot2 = NOP_INST;
    chk("t4_c1_even", iss_even, a1);
    chk("t4_c1_rdy", 96'(in_ready), 96'(1));
    tick(); in_valid = 1'b0; #1;
    find_iss(1'b0, 2, n, got);
    chk("t4_cycle", 96'(n), 96'(7));
    chk("t4_inst", got, b1);

    // T5: flush with slot2 pending; scoreboard keeps counting through the flush
    rst_seq("t5");
    a1 = mk(PIPE_EVEN, 1, 7'd9, 3'd3, 7'd0, 0, 7'd0, 0, 7'h51);
    a2 = mk(PIPE_EVEN, 1, 7'd15, 3'd1, 7'd0, 0, 7'd0, 0, 7'h52);
    b1 = mk(PIPE_ODD,  1, 7'd16, 3'd1, 7'd9, 1, 7'd0, 0, 7'h53);
    offer(a1, a2);
    chk("t5_c1_even", iss_even, a1);
    tick(); flush = 1'b1; #1;
    chk("t5_fl_even", iss_even, NOP_INST);
    chk("t5_fl_odd", iss_odd, NOP_INST);
    chk("t5_fl_rdy", 96'(in_ready), 96'(0));
    tick(); flush = 1'b0; #1;
    chk("t5_c3_rdy", 96'(in_ready), 96'(1));
    chk("t5_c3_even", iss_even, NOP_INST);
    offer(b1, NOP_INST);
    chk("t5_c4_odd", iss_odd, b1);
    chk("t5_stall", 96'(stall_cycles), 96'(1));

    // T6: reset mid-stall clears counters, buffer and stall count
    rst_seq("t6");
    a1 = mk(PIPE_EVEN, 1, 7'd10, 3'd7, 7'd0, 0, 7'd0, 0, 7'h61);
    a2 = mk(PIPE_ODD,  0, 7'd0, 3'd0, 7'd10, 1, 7'd0, 0, 7'h62);
    b1 = mk(PIPE_EVEN, 1, 7'd12, 3'd2, 7'd0, 0, 7'd10, 1, 7'h63);
    b2 = mk(PIPE_ODD,  1, 7'd17, 3'd1, 7'd10, 1, 7'd0, 0, 7'h64);
    offer(a1, a2);
    chk("t6_c1_even", iss_even, a1);
    tick(); tick();
    reset = 1'b1; in_valid = 1'b1; in_slot1 = b1; in_slot2 = b2; #1;
    chk("t6_pre_stall", 96'(stall_cycles), 96'(2));
    chk("t6_rst_rdy", 96'(in_ready), 96'(0));
    chk("t6_rst_even", iss_even, NOP_INST);
    chk("t6_rst_odd", iss_odd, NOP_INST);
    tick(); reset = 1'b0; in_valid = 1'b0; #1;
    chk("t6_post_stall", 96'(stall_cycles), 96'(0));
    chk("t6_post_rdy", 96'(in_ready), 96'(1));
    chk("t6_post_odd", iss_odd, NOP_INST);
    offer(b1, b2);
    chk("t6_new_even", iss_even, b1);
    chk("t6_new_odd", iss_odd, b2);

    // T7: lat 1 intra-pair RAW -> slot2 one cycle behind
    rst_seq("t7");
    a1 = mk(PIPE_EVEN, 1, 7'd6, 3'd1, 7'd0, 0, 7'd0, 0, 7'h71);
    a2 = mk(PIPE_ODD,  0, 7'd0, 3'd0, 7'd6, 1, 7'd0, 0, 7'h72);
    offer(a1, a2);
    chk("t7_c1_even", iss_even, a1);
    chk("t7_c1_odd", iss_odd, NOP_INST);
    tick(); #1;
    chk("t7_c2_odd", iss_odd, a2);

    // T8: intra-pair WAW on same rt, different pipes
    rst_seq("t8");
    a1 = mk(PIPE_EVEN, 1, 7'd18, 3'd1, 7'd0, 0, 7'd0, 0, 7'h01);
    a2 = mk(PIPE_ODD,  1, 7'd18, 3'd1, 7'd0, 0, 7'd0, 0, 7'h02);
    offer(a1, a2);
    chk("t8_c1_even", iss_even, a1);
    chk("t8_c1_odd", iss_odd, NOP_INST);
    tick(); #1;
    chk("t8_c2_odd", iss_odd, a2);
    tick(); #1;
    chk("t8_stall", 96'(stall_cycles), 96'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
